render_sequencer: RTL and testbench
===================================

# render_sequencer

Frame-build controller for the triangle pipeline. It starts the ROM-to-RAM vertex load, walks the triangle table in RAM one triangle at a time, and arms the filled-triangle rasterizer for each one. While a triangle is drawing it gives the rasterizer write ownership of the 1-bit video buffer; at all other times the buffer belongs to the VGA scanout reader. It replaces hand-sequenced `vid_buff_we` and rasterizer `reset` pulses with one FSM.

## Interface
- `NUM_TRIS`, 1: triangles in the RAM table; legal range 1..28.
- `TRI_STRIDE`, 9: RAM words per triangle (x1,y1,z1,x2,y2,z2,x3,y3,z3).
- `SETTLE`, 2: cycles `ram_read_addr` is held before the rasterizer is armed; minimum 1.
- `DRAW_TIMEOUT`, 4096: maximum DRAW cycles per triangle.
- `H_RES`, 640 / `V_RES`, 480: visible area used for write clipping.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request a frame build; level-sampled each cycle.
- `busy` out 1: high while building a frame.
- `done` out 1: one-cycle pulse when the last triangle finishes.
- `err` out 1: sticky flag, set on any draw timeout.
- `rom_start` out 1: ROM2RAM start.
- `rom_finish` in 1: ROM2RAM finish (level).
- `ram_read_addr` out 8: RAM base address of the current triangle.
- `tri_start` out 1: drives the rasterizer `reset`; one-cycle high pulse.
- `tri_finish` in 1: rasterizer finish.
- `tri_x` in 10 / `tri_y` in 9: rasterizer pixel output (OX1/OY1).
- `pix_x` in 10 / `pix_y` in 10: VGA scan position.
- `vga_reset` out 1: active-high hold for Vga_Sync.
- `buf_we` out 1: video buffer write enable; also its `wr_data`.
- `buf_addr` out 19: video buffer address.

## Operation
- States: IDLE, LOAD_REQ, LOAD_WAIT, SELECT, ARM, DRAW, NEXT, SCAN.
- State transitions:
  - IDLE: `start` goes to LOAD_REQ if the table has never been loaded, else to SELECT. `idx` is cleared to 0.
  - LOAD_REQ: `rom_start`=1 for exactly one cycle, then go to LOAD_WAIT.
  - LOAD_WAIT: stay until `rom_finish`=1, then set the internal `loaded` flag and go to SELECT.
  - SELECT: `ram_read_addr` = `idx*TRI_STRIDE`. Hold for `SETTLE` cycles, then go to ARM.
  - ARM: `tri_start`=1 for one cycle, then go to DRAW. The watchdog is cleared.
  - DRAW: `tri_finish` is ignored on the first DRAW cycle, because the rasterizer finish may be stale. From the second cycle on, `tri_finish`=1 goes to NEXT. If the watchdog reaches `DRAW_TIMEOUT`, set `err` and go to NEXT.
  - NEXT: if `idx`==`NUM_TRIS-1`, pulse `done` and go to SCAN; otherwise increment `idx` and go to SELECT.
  - SCAN: `vga_reset`=0. `start` goes to SELECT with `idx`=0 and `vga_reset`=1; there is no reload.
- Buffer arbitration:
  - In DRAW: `buf_addr` = {`tri_x`, `tri_y`}. `buf_we` = 1 only when `tri_x` < `H_RES` and `tri_y` < `V_RES` (clipped otherwise).
  - In all other states: `buf_addr` = {`pix_x[9:0]`, `pix_y[8:0]`} and `buf_we` = 0.
- `vga_reset` is 1 in every state except SCAN.
- `busy` is 1 in every state except IDLE and SCAN.
- `start` while `busy` is ignored.
- `err` clears only on reset.
- Arithmetic:
  - `idx` is 5-bit.
  - The address product is truncated to 8 bits; `NUM_TRIS` ≤ 28 guarantees it does not overflow.
  - The watchdog is 16-bit and saturating.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `rom_start`, `tri_start` = 0; `vga_reset` = 1; `ram_read_addr` = 0; `loaded` = 0; `buf_we` = 0; `buf_addr` follows `pix`.
- All registered outputs change on the `clk` rising edge. `buf_we` and `buf_addr` are combinational from the registered state and current inputs (zero latency).
- `start` to `rom_start`: `start` sampled at edge N gives `rom_start` high during cycle N+1.
- `rom_finish` seen at edge M: SELECT from M+1, and `tri_start` high `SETTLE` cycles later.
- Cycles per triangle: 1 (ARM) + D (DRAW) + 1 (NEXT) + `SETTLE`, where D ≥ 2.
- `done` is high in the cycle that SCAN is entered, one cycle before `vga_reset` falls.
- Reset asserted mid-frame: everything returns to reset values immediately (asynchronous), `loaded` is cleared, and the next `start` reloads the ROM.
- `tri_finish` and the timeout in the same cycle: treated as finish, and `err` is not set.

## Test plan
- Single frame: `NUM_TRIS`=1, `start` pulse, ROM finish after 18 cycles, rasterizer finish after 500 cycles → one `rom_start` pulse, `ram_read_addr`=0, one `tri_start` pulse, `done` once, `vga_reset` falls the next cycle, `err`=0.
- Multi-triangle table: `NUM_TRIS`=3 → `ram_read_addr` takes 0, 9, 18 in order, with three `tri_start` pulses and three DRAW phases separated by `SETTLE`+2 cycles.
- Clipping and arbitration: in DRAW, `tri_x`=700, `tri_y`=10 → `buf_we`=0; (`tri_x`,`tri_y`)=(100,50) → `buf_we`=1 and `buf_addr`={100,50}; in SCAN with `pix_x`=5, `pix_y`=7 → `buf_addr`={5,7} and `buf_we`=0.
- Timeout: `tri_finish` held 0 with `DRAW_TIMEOUT`=64 → exit DRAW after 64 cycles, `err`=1 and sticky, frame still completes with `done`.
- Stale finish and restart: `tri_finish` held high through ARM → DRAW lasts exactly 2 cycles. A `start` in SCAN → no `rom_start`, `vga_reset`=1, redraw from `ram_read_addr`=0.
- Reset mid-DRAW: `reset`=0 during DRAW → outputs at reset values within the same cycle. The next `start` → `rom_start` is pulsed again.

Source files
------------

// File: rtl/render_sequencer.sv
// render_sequencer: frame-build FSM for the triangle pipeline.
// Sequences ROM load, per-triangle raster and video buffer ownership.
module render_sequencer #(
  parameter int NUM_TRIS     = 1,
  parameter int TRI_STRIDE   = 9,
  parameter int SETTLE       = 2,
  parameter int DRAW_TIMEOUT = 4096,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        rom_start,
  input  logic        rom_finish,
  output logic [7:0]  ram_read_addr,
  output logic        tri_start,
  input  logic        tri_finish,
  input  logic [9:0]  tri_x,
  input  logic [8:0]  tri_y,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic        vga_reset,
  output logic        buf_we,
  output logic [18:0] buf_addr
);

  typedef enum logic [2:0] {
    IDLE, LOAD_REQ, LOAD_WAIT, SELECT,
    ARM, DRAW, NEXT, SCAN
  } state_t;

  localparam logic [4:0]  LastIdx = 5'(NUM_TRIS - 1);
  localparam logic [15:0] SetLast = 16'(SETTLE - 1);
  localparam logic [15:0] WdLast  = 16'(DRAW_TIMEOUT - 1);
  localparam logic [7:0]  Stride  = 8'(TRI_STRIDE);
  localparam logic [10:0] HRes    = 11'(H_RES);
  localparam logic [9:0]  VRes    = 10'(V_RES);

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] wd_q, wd_d;
  logic [7:0]  addr_q, addr_d;
  logic        loaded_q, loaded_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rom_q, rom_d;
  logic        tri_q, tri_d;
  logic        vga_q, vga_d;
  logic        unused_pix;

  function automatic logic [7:0] tri_base(input logic [4:0] i);
    tri_base = {3'b000, i} * Stride;
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    wd_d     = wd_q;
    addr_d   = addr_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    rom_d    = 1'b0;
    tri_d    = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d = 5'd0;
          if (loaded_q) begin
            state_d = SELECT;
            cnt_d   = 16'd0;
            addr_d  = 8'd0;
          end else begin
            state_d = LOAD_REQ;
            rom_d   = 1'b1;
          end
        end
      end
      LOAD_REQ: state_d = LOAD_WAIT;
      LOAD_WAIT: begin
        if (rom_finish) begin
          loaded_d = 1'b1;
          state_d  = SELECT;
          cnt_d    = 16'd0;
          addr_d   = tri_base(idx_q);
        end
      end
      SELECT: begin
        if (cnt_q >= SetLast) begin
          state_d = ARM;
          tri_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ARM: begin
        state_d = DRAW;
        wd_d    = 16'd0;
      end
      DRAW: begin
        wd_d = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
        // First DRAW cycle may still see the previous triangle's finish
        if (wd_q != 16'd0 && tri_finish) begin
          state_d = NEXT;
        end else if (wd_q >= WdLast) begin
          err_d   = 1'b1;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (idx_q == LastIdx) begin
          done_d  = 1'b1;
          state_d = SCAN;
        end else begin
          idx_d   = idx_q + 5'd1;
          addr_d  = tri_base(idx_q + 5'd1);
          cnt_d   = 16'd0;
          state_d = SELECT;
        end
      end
      SCAN: begin
        if (start) begin
          idx_d   = 5'd0;
          addr_d  = 8'd0;
          cnt_d   = 16'd0;
          state_d = SELECT;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = !(state_d == IDLE || state_d == SCAN);
    vga_d  = !(state_q == SCAN && state_d == SCAN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= 5'd0;
      cnt_q    <= 16'd0;
      wd_q     <= 16'd0;
      addr_q   <= 8'd0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rom_q    <= 1'b0;
      tri_q    <= 1'b0;
      vga_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      addr_q   <= addr_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rom_q    <= rom_d;
      tri_q    <= tri_d;
      vga_q    <= vga_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign rom_start     = rom_q;
  assign tri_start     = tri_q;
  assign vga_reset     = vga_q;
  assign ram_read_addr = addr_q;
  assign unused_pix    = pix_y[9];

  // Rasterizer owns the buffer only while drawing; off-screen pixels dropped
  always_comb begin
    buf_we   = 1'b0;
    buf_addr = {pix_x, pix_y[8:0]};
    if (state_q == DRAW) begin
      buf_addr = {tri_x, tri_y};
      buf_we   = ({1'b0, tri_x} < HRes) && ({1'b0, tri_y} < VRes);
    end
  end

endmodule

// File: tb/tb_render_sequencer.sv
// tb_render_sequencer: directed frame builds with an address scoreboard.
// Three-triangle table, short watchdog to reach the timeout path.
module tb_render_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rom_finish;
  logic        tri_finish;
  logic [9:0]  tri_x;
  logic [8:0]  tri_y;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        busy, done, err, rom_start, tri_start;
  logic        vga_reset, buf_we;
  logic [7:0]  ram_read_addr;
  logic [18:0] buf_addr;

  int checks   = 0;
  int errors   = 0;
  int rom_cnt  = 0;
  int tri_cnt  = 0;
  int done_cnt = 0;
  int cyc      = 0;
  logic [7:0] exp_addr[$];
  int ts[$];

  render_sequencer #(
    .NUM_TRIS(3), .TRI_STRIDE(9), .SETTLE(2),
    .DRAW_TIMEOUT(64), .H_RES(640), .V_RES(480)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .err(err),
    .rom_start(rom_start), .rom_finish(rom_finish),
    .ram_read_addr(ram_read_addr),
    .tri_start(tri_start), .tri_finish(tri_finish),
    .tri_x(tri_x), .tri_y(tri_y),
    .pix_x(pix_x), .pix_y(pix_y),
    .vga_reset(vga_reset), .buf_we(buf_we),
    .buf_addr(buf_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rom_start) rom_cnt++;
    if (done) done_cnt++;
    if (tri_start) begin
      tri_cnt++;
      ts.push_back(cyc);
      check("sb_pending", 32'(exp_addr.size() != 0), 1);
      if (exp_addr.size() != 0)
        check("ram_read_addr", 32'(ram_read_addr), 32'(exp_addr.pop_front()));
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_tri();
    int n = 0;
    while (!tri_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tri_start_seen", 32'(tri_start), 1);
  endtask

  // mode 0 finish at DRAW cycle k, 1 also clip checks,
  // 2 never finish, 3 finish held high from before ARM
  task automatic serve(input int k, input int mode);
    if (mode == 3) tri_finish = 1'b1;
    wait_tri();
    for (int j = 1; j <= k; j++) begin
      @(negedge clk);
      if (mode == 1 && j == 1) begin
        tri_x = 10'd700; tri_y = 9'd10;
        #1;
        check("clip_we", 32'(buf_we), 0);
      end
      if (mode == 1 && j == 2) begin
        tri_x = 10'd100; tri_y = 9'd50;
        #1;
        check("draw_we", 32'(buf_we), 1);
        check("draw_addr", 32'(buf_addr), 32'({10'd100, 9'd50}));
      end
      if (mode != 2 && j == k) tri_finish = 1'b1;
    end
    @(negedge clk);
    tri_finish = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0;
    rom_finish = 1'b0; tri_finish = 1'b0;
    tri_x = 10'd0; tri_y = 9'd0;
    pix_x = 10'd3; pix_y = 10'd514;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_rom_start", 32'(rom_start), 0);
    check("rst_tri_start", 32'(tri_start), 0);
    check("rst_vga_reset", 32'(vga_reset), 1);
    check("rst_addr", 32'(ram_read_addr), 0);
    check("rst_buf_we", 32'(buf_we), 0);
    check("rst_buf_addr", 32'(buf_addr), 32'({10'd3, 9'd2}));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // frame 1: load then three triangles
    exp_addr.push_back(8'd0);
    exp_addr.push_back(8'd9);
    exp_addr.push_back(8'd18);
    pulse_start();
    check("f1_rom_start", 32'(rom_start), 1);
    check("f1_busy", 32'(busy), 1);
    @(negedge clk);
    check("f1_rom_start_drop", 32'(rom_start), 0);
    repeat (16) @(negedge clk);
    check("f1_no_tri_in_load", 32'(tri_cnt), 0);
    rom_finish = 1'b1;
    @(negedge clk);
    rom_finish = 1'b0;
    check("f1_sel1_tri", 32'(tri_start), 0);
    @(negedge clk);
    check("f1_sel2_tri", 32'(tri_start), 0);
    @(negedge clk);
    check("f1_arm_tri", 32'(tri_start), 1);
    serve(20, 1);
    serve(5, 0);
    serve(3, 0);
    @(negedge clk);
    check("f1_done", 32'(done), 1);
    check("f1_vga_hold", 32'(vga_reset), 1);
    check("f1_busy_end", 32'(busy), 0);
    @(negedge clk);
    check("f1_done_drop", 32'(done), 0);
    check("f1_vga_fall", 32'(vga_reset), 0);
    check("f1_err", 32'(err), 0);
    check("f1_rom_cnt", 32'(rom_cnt), 1);
    check("f1_tri_cnt", 32'(tri_cnt), 3);
    check("f1_done_cnt", 32'(done_cnt), 1);
    check("f1_gap01", 32'(ts[1] - ts[0]), 24);
    check("f1_gap12", 32'(ts[2] - ts[1]), 9);
    ts.delete();

    pix_x = 10'd5; pix_y = 10'd7;
    #1;
    check("scan_addr", 32'(buf_addr), 32'({10'd5, 9'd7}));
    check("scan_we", 32'(buf_we), 0);
    @(negedge clk);

    // frame 2: restart from SCAN, timeout then stale finish
    exp_addr.push_back(8'd0);
    exp_addr.push_back(8'd9);
    exp_addr.push_back(8'd18);
    pulse_start();
    check("f2_no_rom_start", 32'(rom_start), 0);
    check("f2_vga_reset", 32'(vga_reset), 1);
    check("f2_busy", 32'(busy), 1);
    serve(64, 2);
    check("f2_err_set", 32'(err), 1);
    serve(2, 3);
    serve(4, 0);
    @(negedge clk);
    check("f2_done", 32'(done), 1);
    check("f2_err_sticky", 32'(err), 1);
    @(negedge clk);
    check("f2_vga_fall", 32'(vga_reset), 0);
    check("f2_rom_cnt", 32'(rom_cnt), 1);
    check("f2_done_cnt", 32'(done_cnt), 2);
    check("f2_gap_timeout", 32'(ts[1] - ts[0]), 68);
    check("f2_gap_stale", 32'(ts[2] - ts[1]), 6);
    ts.delete();

    // frame 3: reset during the second triangle's DRAW
    exp_addr.push_back(8'd0);
    exp_addr.push_back(8'd9);
    pulse_start();
    serve(3, 0);
    wait_tri();
    @(negedge clk);
    tri_x = 10'd100; tri_y = 9'd50;
    #1;
    check("f3_pre_we", 32'(buf_we), 1);
    reset = 1'b0;
    #1;
    check("f3_rst_busy", 32'(busy), 0);
    check("f3_rst_err", 32'(err), 0);
    check("f3_rst_vga", 32'(vga_reset), 1);
    check("f3_rst_addr", 32'(ram_read_addr), 0);
    check("f3_rst_we", 32'(buf_we), 0);
    check("f3_rst_done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pulse_start();
    check("f3_reload", 32'(rom_start), 1);
    @(negedge clk);
    check("f3_rom_cnt", 32'(rom_cnt), 2);
    check("sb_drained", 32'(exp_addr.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
